// File: rtl/tau_decoder.sv
// -----------------------------------------------------------------------------
// tau_decoder
//
// Purpose:
//   Rebuilds a binary value from a frame of one-hot "tau" words. A frame opens
//   with a one-cycle start pulse. Each valid word ORs its single set bit into
//   an accumulator. The first cycle after the start cycle with count_by_valid
//   low closes the frame. The decoded value, the number of words in the frame
//   and an error flag are registered together with a one-cycle n_valid pulse.
//   For a frame from the tau encoder, the decoded value n equals the encoded
//   value v, and word_count equals popcount(v).
//
// Parameters:
//   BITWIDTH        width of the one-hot word and of the decoded value
//
// Ports:
//   clk             sole clock, rising edge
//   reset_n         asynchronous active-low reset
//   start           one-cycle pulse marking the first cycle of a frame
//   count_by        one-hot tau word, qualified by count_by_valid
//   count_by_valid  count_by carries a word this cycle
//   n               decoded value of the last completed frame
//   n_valid         one-cycle pulse: n, word_count and err were just updated
//   word_count      number of words in the last completed frame
//   err             last completed frame contained a protocol violation
//   busy            high while a frame is being collected
//
// Configuration macro:
//   TAU_DECODER_ORDER_CHECK_EN
//     When defined, each word inside a frame must have a bit index strictly
//     below the index of the previous word in that frame. The encoder emits
//     words MSB first. Any other order sets the frame error. When the macro
//     is undefined, word order is not checked and no position register is
//     built.
// -----------------------------------------------------------------------------
module tau_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [BITWIDTH-1:0]       count_by,
  input  logic                      count_by_valid,
  output logic [BITWIDTH-1:0]       n,
  output logic                      n_valid,
  output logic [$clog2(BITWIDTH):0] word_count,
  output logic                      err,
  output logic                      busy
);

  // Word counter width. It holds the values 0..BITWIDTH inclusive.
  localparam int CW = $clog2(BITWIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // A word is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  function automatic logic is_onehot(input logic [BITWIDTH-1:0] w);
    return (w != '0) && ((w & (w - 1'b1)) == '0);
  endfunction

  // Next counter value. The counter stops at BITWIDTH, so a frame with extra
  // words cannot wrap the count.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CW'(BITWIDTH)) begin
      return CW'(BITWIDTH);
    end
    return c + CW'(1);
  endfunction

`ifdef TAU_DECODER_ORDER_CHECK_EN
  // Width of a bit index. It is kept at least 1 bit wide so that
  // BITWIDTH == 1 still elaborates.
  localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  // Index of the highest set bit. A malformed word with several bits set is
  // placed by its top bit. That bit bounds the position, and the word is
  // already flagged by the one-hot check. A zero word maps to index 0.
  function automatic logic [IW-1:0] bit_index(input logic [BITWIDTH-1:0] w);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      if (w[i]) begin
        idx = IW'(i);
      end
    end
    return idx;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                state_q,  state_d;
  logic [BITWIDTH-1:0]   acc_q,    acc_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic                  ferr_q,   ferr_d;
  logic [BITWIDTH-1:0]   n_q,      n_d;
  logic [CW-1:0]         wc_q,     wc_d;
  logic                  err_q,    err_d;
  logic                  nvld_q,   nvld_d;

  // A bad word is only meaningful when a word is actually presented.
  logic word_bad;
  assign word_bad = count_by_valid && !is_onehot(count_by);

`ifdef TAU_DECODER_ORDER_CHECK_EN
  logic [IW-1:0] pos_q, pos_d;
  logic [IW-1:0] word_idx;
  logic          order_bad;

  assign word_idx  = bit_index(count_by);
  // Only used when a word continues a frame. A start word has no predecessor.
  assign order_bad = count_by_valid && (word_idx >= pos_q);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ferr_d  = ferr_q;
    n_d     = n_q;
    wc_d    = wc_q;
    err_d   = err_q;
    nvld_d  = 1'b0;
`ifdef TAU_DECODER_ORDER_CHECK_EN
    pos_d   = pos_q;
`endif

    if (start) begin
      // A start pulse always opens a fresh frame. Any frame in progress is
      // dropped silently.
      if (count_by_valid) begin
        state_d = COLLECT;
        acc_d   = count_by;
        cnt_d   = CW'(1);
        ferr_d  = word_bad;
`ifdef TAU_DECODER_ORDER_CHECK_EN
        pos_d   = word_idx;
`endif
      end else begin
        // Empty frame: it completes at once with an all-zero result.
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ferr_d  = 1'b0;
        n_d     = '0;
        wc_d    = '0;
        err_d   = 1'b0;
        nvld_d  = 1'b1;
`ifdef TAU_DECODER_ORDER_CHECK_EN
        pos_d   = '0;
`endif
      end
    end else if (state_q == COLLECT) begin
      if (count_by_valid) begin
        acc_d  = acc_q | count_by;
        cnt_d  = sat_inc(cnt_q);
`ifdef TAU_DECODER_ORDER_CHECK_EN
        ferr_d = ferr_q | word_bad | order_bad;
        pos_d  = word_idx;
`else
        ferr_d = ferr_q | word_bad;
`endif
      end else begin
        // The first gap closes the frame. The result is published on this edge.
        state_d = IDLE;
        n_d     = acc_q;
        wc_d    = cnt_q;
        err_d   = ferr_q;
        nvld_d  = 1'b1;
      end
    end
    // In IDLE without start, count_by and count_by_valid are ignored.
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      n_q     <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      nvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
      n_q     <= n_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      nvld_q  <= nvld_d;
    end
  end

`ifdef TAU_DECODER_ORDER_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign n          = n_q;
  assign n_valid    = nvld_q;
  assign word_count = wc_q;
  assign err        = err_q;
  assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_tau_decoder.sv
// -----------------------------------------------------------------------------
// tb_tau_decoder
//
// Purpose:
//   Directed, self-checking bench for tau_decoder at BITWIDTH = 8. It covers
//   these cases:
//     - reset state
//     - basic and empty frames
//     - malformed and zero words
//     - word order (the expected error depends on TAU_DECODER_ORDER_CHECK_EN)
//     - restart mid-frame
//     - full frames and the count saturation boundary
//     - words presented while idle
//     - back-to-back frames
//     - asynchronous reset mid-frame
//
// Timing:
//   Inputs are driven, and outputs are sampled, 1 time unit after each rising
//   clock edge.
// -----------------------------------------------------------------------------
module tb_tau_decoder;

  localparam int BW = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [BW-1:0] count_by;
  logic          count_by_valid;
  logic [BW-1:0] n;
  logic          n_valid;
  logic [3:0]    word_count;
  logic          err;
  logic          busy;

  int checks;
  int errors;

`ifdef TAU_DECODER_ORDER_CHECK_EN
  localparam logic ORDER_ERR = 1'b1;
`else
  localparam logic ORDER_ERR = 1'b0;
`endif

  tau_decoder #(.BITWIDTH(BW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .count_by       (count_by),
    .count_by_valid (count_by_valid),
    .n              (n),
    .n_valid        (n_valid),
    .word_count     (word_count),
    .err            (err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only; every check is made inline in the tests)
  // ---------------------------------------------------------------------------

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic st, input logic [BW-1:0] w);
    start          = st;
    count_by       = w;
    count_by_valid = 1'b1;
    tick();
  endtask

  task automatic gap();
    start          = 1'b0;
    count_by       = '0;
    count_by_valid = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------

  task automatic test_reset();
    reset_n        = 1'b0;
    start          = 1'b0;
    count_by       = '0;
    count_by_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({n, word_count, err, n_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got n=%h wc=%0d err=%b nv=%b busy=%b required all 0",
               n, word_count, err, n_valid, busy);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (n_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got nv=%b busy=%b required 0 0", n_valid, busy);
    end
  endtask

  task automatic test_basic();
    word(1'b1, 8'h08);
    checks++;
    if (busy !== 1'b1 || n_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got busy=%b nv=%b required 1 0", busy, n_valid);
    end
    word(1'b0, 8'h02);
    word(1'b0, 8'h01);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h0B || word_count !== 4'd3 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got nv=%b n=%h wc=%0d err=%b busy=%b required 1 0b 3 0 0",
               n_valid, n, word_count, err, busy);
    end
    gap();
    checks++;
    if (n_valid !== 1'b0 || n !== 8'h0B || word_count !== 4'd3) begin
      errors++;
      $display("FAIL basic_hold got nv=%b n=%h wc=%0d required 0 0b 3", n_valid, n, word_count);
    end
  endtask

  task automatic test_empty();
    start          = 1'b1;
    count_by       = 8'hFF;
    count_by_valid = 1'b0;
    tick();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h00 || word_count !== 4'd0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_frame got nv=%b n=%h wc=%0d err=%b busy=%b required 1 00 0 0 0",
               n_valid, n, word_count, err, busy);
    end
    gap();
    checks++;
    if (n_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pulse_width got nv=%b required 0", n_valid);
    end
  endtask

  task automatic test_bad_words();
    // A multi-bit word is not one-hot.
    word(1'b1, 8'h80);
    word(1'b0, 8'h03);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h83 || word_count !== 4'd2 || err !== 1'b1) begin
      errors++;
      $display("FAIL multibit got nv=%b n=%h wc=%0d err=%b required 1 83 2 1",
               n_valid, n, word_count, err);
    end
    // A zero word is not one-hot either.
    word(1'b1, 8'h04);
    word(1'b0, 8'h00);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h04 || word_count !== 4'd2 || err !== 1'b1) begin
      errors++;
      $display("FAIL zero_word got nv=%b n=%h wc=%0d err=%b required 1 04 2 1",
               n_valid, n, word_count, err);
    end
    // A clean frame afterwards must clear err again.
    word(1'b1, 8'h01);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h01 || word_count !== 4'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_clears got nv=%b n=%h wc=%0d err=%b required 1 01 1 0",
               n_valid, n, word_count, err);
    end
  endtask

  task automatic test_order();
    word(1'b1, 8'h02);
    word(1'b0, 8'h08);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h0A || word_count !== 4'd2 || err !== ORDER_ERR) begin
      errors++;
      $display("FAIL order_ascending got nv=%b n=%h wc=%0d err=%b required 1 0a 2 %b",
               n_valid, n, word_count, err, ORDER_ERR);
    end
    // A repeated index is also out of order.
    word(1'b1, 8'h04);
    word(1'b0, 8'h04);
    gap();
    checks++;
    if (n !== 8'h04 || word_count !== 4'd2 || err !== ORDER_ERR) begin
      errors++;
      $display("FAIL order_repeat got n=%h wc=%0d err=%b required 04 2 %b",
               n, word_count, err, ORDER_ERR);
    end
  endtask

  task automatic test_restart();
    word(1'b1, 8'h40);
    word(1'b0, 8'h10);
    word(1'b1, 8'h04);
    checks++;
    if (n_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_no_pulse got nv=%b busy=%b required 0 1", n_valid, busy);
    end
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h04 || word_count !== 4'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_result got nv=%b n=%h wc=%0d err=%b required 1 04 1 0",
               n_valid, n, word_count, err);
    end
    gap();
    checks++;
    if (n_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_single_pulse got nv=%b required 0", n_valid);
    end
  endtask

  task automatic test_encoder_frames();
    // v = 0xB5: words MSB first, popcount 5.
    word(1'b1, 8'h80);
    word(1'b0, 8'h20);
    word(1'b0, 8'h10);
    word(1'b0, 8'h04);
    word(1'b0, 8'h01);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'hB5 || word_count !== 4'd5 || err !== 1'b0) begin
      errors++;
      $display("FAIL encoder_b5 got nv=%b n=%h wc=%0d err=%b required 1 b5 5 0",
               n_valid, n, word_count, err);
    end
    // v = 0xFF: the full frame reaches the maximum count of 8.
    word(1'b1, 8'h80);
    for (int i = 6; i >= 0; i--) word(1'b0, 8'(1 << i));
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'hFF || word_count !== 4'd8 || err !== 1'b0) begin
      errors++;
      $display("FAIL encoder_ff got nv=%b n=%h wc=%0d err=%b required 1 ff 8 0",
               n_valid, n, word_count, err);
    end
    // Nine words: the count saturates at 8. The trailing 0x01 repeats index 0.
    word(1'b1, 8'h80);
    for (int i = 6; i >= 0; i--) word(1'b0, 8'(1 << i));
    word(1'b0, 8'h01);
    gap();
    checks++;
    if (n !== 8'hFF || word_count !== 4'd8 || err !== ORDER_ERR) begin
      errors++;
      $display("FAIL count_saturate got n=%h wc=%0d err=%b required ff 8 %b",
               n, word_count, err, ORDER_ERR);
    end
  endtask

  task automatic test_idle_ignore();
    // The previous frame left n=ff and wc=8.
    for (int i = 0; i < 3; i++) begin
      word(1'b0, 8'h03);
      checks++;
      if (n_valid !== 1'b0 || busy !== 1'b0 || n !== 8'hFF || word_count !== 4'd8) begin
        errors++;
        $display("FAIL idle_ignore got nv=%b busy=%b n=%h wc=%0d required 0 0 ff 8",
                 n_valid, busy, n, word_count);
      end
    end
    gap();
    checks++;
    if (n_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_gap got nv=%b required 0", n_valid);
    end
  endtask

  task automatic test_back_to_back();
    word(1'b1, 8'h10);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h10 || word_count !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first got nv=%b n=%h wc=%0d required 1 10 1", n_valid, n, word_count);
    end
    word(1'b1, 8'h20);
    checks++;
    if (n_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got nv=%b busy=%b required 0 1", n_valid, busy);
    end
    word(1'b0, 8'h01);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h21 || word_count !== 4'd2 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got nv=%b n=%h wc=%0d err=%b required 1 21 2 0",
               n_valid, n, word_count, err);
    end
  endtask

  task automatic test_reset_midframe();
    word(1'b1, 8'h20);
    // Hold 0x20 valid so the frame stays open through the reset.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({n, word_count, err, n_valid, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset got n=%h wc=%0d err=%b nv=%b busy=%b required all 0",
               n, word_count, err, n_valid, busy);
    end
    tick();
    reset_n = 1'b1;
    // Words without a start must not reopen a frame or produce a pulse.
    for (int i = 0; i < 2; i++) begin
      word(1'b0, 8'h08);
      checks++;
      if (n_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got nv=%b busy=%b required 0 0", n_valid, busy);
      end
    end
    gap();
    checks++;
    if (n_valid !== 1'b0 || n !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_no_pulse got nv=%b n=%h required 0 00", n_valid, n);
    end
    word(1'b1, 8'h02);
    gap();
    checks++;
    if (n_valid !== 1'b1 || n !== 8'h02 || word_count !== 4'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame got nv=%b n=%h wc=%0d err=%b required 1 02 1 0",
               n_valid, n, word_count, err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_empty();
    test_bad_words();
    test_order();
    test_restart();
    test_encoder_frames();
    test_idle_ignore();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
